// File: rtl/decoder_n_pkg.sv
// Shared types and limits for the decoder_n block.
package decoder_n_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } decoder_n_state_t;

  localparam int DECODER_N_MAX_SEL_W = 8;

endpackage

// File: rtl/decoder_n_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder.
module decoder_n_onehot #(
  parameter int  SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] code_i,
  output logic [OUT_W-1:0] onehot_o
);

  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  // Single set bit at the position named by code_i.
  always_comb begin
    onehot_o = ONE << code_i;
  end

endmodule

// File: rtl/decoder_n.sv
// Registered one-hot decoder with valid/ready input and optional scan walk.
// Build option: DECODER_N_SCAN_EN adds the SCAN state (walk d[0]..d[sel],
// each code held HOLD cycles, done pulse at the end). Without it every
// accept is a direct decode, sel_ready is tied high and done tied low.
//
// state | meaning
// IDLE  | ready for a request; d holds the last decoded code (or 0)
// SCAN  | walking step 0..target, each code held HOLD cycles
module decoder_n
  import decoder_n_pkg::*;
#(
  parameter int  SEL_W = 3,
  parameter int  HOLD  = 1,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  output logic [OUT_W-1:0] d,
  output logic             d_valid,
  output logic             done
);

  if (SEL_W < 1 || SEL_W > DECODER_N_MAX_SEL_W) begin : g_bad_sel_w
    $error("decoder_n: SEL_W out of range 1..%0d", DECODER_N_MAX_SEL_W);
  end

  logic [SEL_W-1:0] code_sel;
  logic [OUT_W-1:0] code_onehot;
  logic [OUT_W-1:0] d_q, d_d;
  logic             d_valid_q, d_valid_d;

  decoder_n_onehot #(.SEL_W(SEL_W)) u_onehot (
    .code_i   (code_sel),
    .onehot_o (code_onehot)
  );

`ifdef DECODER_N_SCAN_EN

  if (HOLD < 1) begin : g_bad_hold
    $error("decoder_n: HOLD must be at least 1");
  end

  localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD - 1);

  decoder_n_state_t  state_q, state_d;
  logic [SEL_W-1:0]  step_q, step_d;
  logic [SEL_W-1:0]  target_q, target_d;
  logic [HCNT_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;

  // Decoder source: first walk code on a scan accept, next walk code while
  // scanning, otherwise the requested code.
  always_comb begin
    code_sel = sel;
    if (state_q == SCAN) begin
      code_sel = step_q + 1'b1;
    end else if (mode) begin
      code_sel = '0;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    d_valid_d = 1'b0;
    done_d    = 1'b0;
    step_d    = step_q;
    target_d  = target_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          d_d       = code_onehot;
          d_valid_d = 1'b1;
          if (mode) begin
            state_d  = SCAN;
            target_d = sel;
            step_d   = '0;
            hold_d   = '0;
          end
        end
      end
      SCAN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (step_q == target_q) begin
            state_d = IDLE;
            d_d     = '0;
            done_d  = 1'b1;
          end else begin
            step_d    = step_q + 1'b1;
            d_d       = code_onehot;
            d_valid_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= '0;
      target_q  <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      done_q    <= done_d;
      step_q    <= step_d;
      target_q  <= target_d;
      hold_q    <= hold_d;
    end
  end

  assign sel_ready = (state_q == IDLE);
  assign done      = done_q;

`else

  logic unused_cfg;
  assign unused_cfg = mode ^ (HOLD > 0);

  // Direct decode only.
  always_comb begin
    code_sel = sel;
  end

  // Every request is accepted and decoded on the next edge.
  always_comb begin
    d_d       = d_q;
    d_valid_d = 1'b0;
    if (sel_valid) begin
      d_d       = code_onehot;
      d_valid_d = 1'b1;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q       <= '0;
      d_valid_q <= 1'b0;
    end else begin
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign sel_ready = 1'b1;
  assign done      = 1'b0;

`endif

  assign d       = d_q;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_decoder_n.sv
// Self-checking bench for decoder_n (SEL_W = 3, HOLD = 2). Expected outputs
// come from a schedule model: a scan accept expands into the list of per-cycle
// output records it must produce.
module tb_decoder_n;

  localparam int TB_SEL_W = 3;
  localparam int TB_OUT_W = 8;
  localparam int TB_HOLD  = 2;
`ifdef DECODER_N_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                sel_valid = 1'b0;
  logic                sel_ready;
  logic [TB_SEL_W-1:0] sel = '0;
  logic                mode = 1'b0;
  logic [TB_OUT_W-1:0] d;
  logic                d_valid;
  logic                done;

  decoder_n #(.SEL_W(TB_SEL_W), .HOLD(TB_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel       (sel),
    .mode      (mode),
    .d         (d),
    .d_valid   (d_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TB_OUT_W-1:0] d;
    logic                dv;
    logic                dn;
  } rec_t;

  rec_t                sched[$];
  logic [TB_OUT_W-1:0] m_d = '0;
  logic                m_dv = 1'b0;
  logic                m_done = 1'b0;
  int                  checks = 0;
  int                  failures = 0;

  task automatic check(input string tag, input logic [TB_OUT_W-1:0] obs,
                       input logic [TB_OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_sched();
    rec_t r;
    r      = sched.pop_front();
    m_d    = r.d;
    m_dv   = r.dv;
    m_done = r.dn;
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, compare.
  task automatic step(input logic v, input logic [TB_SEL_W-1:0] s,
                      input logic m, input logic r);
    logic acc;
    rec_t rc;
    @(negedge clk);
    sel_valid = v;
    sel       = s;
    mode      = m;
    rst       = r;
    acc = v && (sched.size() == 0);
    @(posedge clk);
    if (r) begin
      sched.delete();
      m_d = '0; m_dv = 1'b0; m_done = 1'b0;
    end else if (acc && m && SCAN_EN) begin
      for (int i = 0; i <= int'(s); i++) begin
        for (int h = 0; h < TB_HOLD; h++) begin
          rc.d  = TB_OUT_W'(1) << i;
          rc.dv = (h == 0);
          rc.dn = 1'b0;
          sched.push_back(rc);
        end
      end
      rc.d = '0; rc.dv = 1'b0; rc.dn = 1'b1;
      sched.push_back(rc);
      pop_sched();
    end else if (acc) begin
      m_d = TB_OUT_W'(1) << s; m_dv = 1'b1; m_done = 1'b0;
    end else if (sched.size() > 0) begin
      pop_sched();
    end else begin
      m_dv = 1'b0; m_done = 1'b0;
    end
    #1;
    check("d", d, m_d);
    check("d_valid", 8'(d_valid), 8'(m_dv));
    check("done", 8'(done), 8'(m_done));
    check("sel_ready", 8'(sel_ready), 8'(sched.size() == 0));
  endtask

  initial begin
    // reset for two cycles
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    // direct decode and hold
    step(1'b1, 3'd5, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd2, 1'b0, 1'b0);
    // back-to-back direct
    step(1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    // scan to 3 with a direct request held through the walk
    step(1'b1, 3'd3, 1'b1, 1'b0);
    repeat (10) step(1'b1, 3'd5, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    // scan boundaries
    step(1'b1, 3'd0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b0);
    repeat (17) step(1'b0, 3'd0, 1'b0, 1'b0);
    // reset during step 2 of a full walk
    step(1'b1, 3'd7, 1'b1, 1'b0);
    repeat (4) step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 3'd0, 1'b0, 1'b0);
    // mode=1 request (direct response when scan is not built in)
    step(1'b1, 3'd4, 1'b1, 1'b0);
    repeat (10) step(1'b0, 3'd0, 1'b0, 1'b0);
    // random traffic, including occasional reset and reset-with-request
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
    end
    repeat (20) step(1'b0, 3'd0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
